// File: rtl/instr_pkg.sv
// Instruction field layout and encode helper shared with the instruction decoder.
package instr_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned OPC_W    = 4;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned IMM_W    = 8;

  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 9;
  localparam int unsigned FLAG_BIT = 8;
  localparam int unsigned RA_MSB   = 7;
  localparam int unsigned RA_LSB   = 5;
  localparam int unsigned RB_MSB   = 4;
  localparam int unsigned RB_LSB   = 2;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;

  typedef enum logic {
    FMT_REG = 1'b0,
    FMT_IMM = 1'b1
  } fmt_e;

  // Pack one decoded field set into an instruction word; fields unused by the form are dropped.
  function automatic logic [INSTR_W-1:0] encode(
    input fmt_e             fmt,
    input logic [OPC_W-1:0] opcode,
    input logic [REG_W-1:0] rd,
    input logic             flag,
    input logic [REG_W-1:0] ra,
    input logic [REG_W-1:0] rb,
    input logic [IMM_W-1:0] imm
  );
    logic [INSTR_W-1:0] word;
    word                   = '0;
    word[OPC_MSB:OPC_LSB]  = opcode;
    word[RD_MSB:RD_LSB]    = rd;
    word[FLAG_BIT]         = flag;
    if (fmt == FMT_IMM) begin
      word[IMM_MSB:IMM_LSB] = imm;
    end else begin
      word[RA_MSB:RA_LSB]   = ra;
      word[RB_MSB:RB_LSB]   = rb;
    end
    return word;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-set input and encoded-word output handshakes of the instruction encoder.
interface instruction_encoder_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
);
  import instr_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic               in_fmt;
  logic [OPC_W-1:0]   in_opcode;
  logic [REG_W-1:0]   in_rD;
  logic               in_flag;
  logic [REG_W-1:0]   in_rA;
  logic [REG_W-1:0]   in_rB;
  logic [IMM_W-1:0]   in_imm;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instruct;
  logic [ADDR_W-1:0]  out_addr;
  logic [CNT_W-1:0]   count;

  // Program-loader side.
  modport master (
    output in_valid, in_fmt, in_opcode, in_rD, in_flag, in_rA, in_rB, in_imm, out_ready,
    input  in_ready, out_valid, out_instruct, out_addr, count
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rD, in_flag, in_rA, in_rB, in_imm, out_ready,
    output in_ready, out_valid, out_instruct, out_addr, count
  );

endinterface

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
module instr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is forced to zero when nothing is buffered so stale storage never shows.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; contents are don't-care after reset or clear.
  always_ff @(posedge clock) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes field sets into instruction words, buffers them and tags each with a write address.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  instruction_encoder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [INSTR_W-1:0] enc_word;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  // Field packing happens ahead of the FIFO write; no bypass to the output.
  assign enc_word = encode(fmt_e'(bus.in_fmt), bus.in_opcode, bus.in_rD, bus.in_flag,
                           bus.in_rA, bus.in_rB, bus.in_imm);

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (bus.in_valid),
    .pop     (bus.out_ready),
    .wdata   (enc_word),
    .rdata   (bus.out_instruct),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Handshake flags decode registered occupancy only.
  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = !fifo_empty;
  assign bus.count     = fifo_count;
  assign bus.out_addr  = addr;

  // Address of the head word; advances on each accepted pop and wraps silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (bus.out_ready && !fifo_empty) begin
      addr <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Packs decoded instruction fields (opcode, rD, flag, rA/rB or imm) back into 16-bit instruction words, the inverse of the instruction decoder.
- Buffers encoded words in a small FIFO and tags each word with a sequential instruction-memory write address.
- Sits between a test/program-loader front end and instruction memory.
- Input and output both use valid/ready handshakes.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- ADDR_W, 8, width of the write-address counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous: flush FIFO, address counter back to 0.
- in_valid  in  1  field set presented.
- in_ready  out  1  encoder can accept a field set.
- in_fmt  in  1  0 = register form, 1 = immediate form.
- in_opcode  in  4  opcode field.
- in_rD  in  3  destination register.
- in_flag  in  1  flag bit.
- in_rA  in  3  source A, register form only.
- in_rB  in  3  source B, register form only.
- in_imm  in  8  immediate, immediate form only.
- out_valid  out  1  encoded word available.
- out_ready  in  1  downstream accepts the word.
- out_instruct  out  16  encoded instruction.
- out_addr  out  ADDR_W  write address for out_instruct.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low (`reset_n`).
- Reset values: in_ready=1, out_valid=0, out_instruct=0, out_addr=0, count=0, FIFO pointers=0.
- Encoding (combinational before the FIFO write):
  - [15:12]=opcode, [11:9]=rD, [8]=flag.
  - fmt=0: [7:5]=rA, [4:2]=rB, [1:0]=2'b00.
  - fmt=1: [7:0]=imm.
  - Unused fields are ignored.
- Push: on a clock edge where in_valid && in_ready, the encoded word is written at the write pointer and count increments.
- Pop: on a clock edge where out_valid && out_ready, the read pointer advances, count decrements and the address counter increments.
- Latency: a word accepted in cycle N is visible on out_* in cycle N+1 at the earliest. There is no combinational bypass.
- in_ready = (count != DEPTH). It depends only on registered state, with no dependence on out_ready.
- out_valid = (count != 0). out_instruct is the FIFO head.
- out_addr is the address-counter register. It is the address of the current head word.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0. A push attempt is ignored even if a pop occurs in the same cycle.
- Empty: out_valid=0. out_ready is ignored and the address does not advance.
- Pointer wrap: pointers wrap modulo DEPTH.
- Address wrap: the address counter wraps from 2^ADDR_W-1 to 0 with no flag.
- clear has priority over push and pop in the same cycle. Next cycle: count=0, out_valid=0, out_addr=0, in_ready=1.
- Stable output: while out_valid && !out_ready, out_instruct and out_addr hold stable.
- Reset mid-operation: immediate return to the reset values. FIFO contents are discarded, so they need not be cleared.

Decomposition:
- Package instr_pkg:
  - field bit positions: OPC_MSB/LSB, RD_MSB/LSB, FLAG_BIT, RA_MSB/LSB, RB_MSB/LSB, IMM_MSB/LSB.
  - INSTR_W=16.
  - fmt enum {FMT_REG=0, FMT_IMM=1}.
  - encode function.
  - Shared with the instruction decoder.
- Sub-module instr_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH, push/pop/clear ports and a count output.
- instruction_encoder contains the encode logic, the address counter and the handshake glue.

Test Plan:
- Register form: fmt=0, opcode=4'hA, rD=3, flag=1, rA=5, rB=2, out_ready=1 → cycle+1: out_valid=1, out_instruct=16'hA7A8, out_addr=0. Next pop gives out_addr=1.
- Immediate form: fmt=1, opcode=3, rD=7, flag=0, imm=8'h5C (rA/rB random) → out_instruct=16'h3E5C.
- Backpressure: out_ready=0, 5 consecutive pushes → count=4 after 4 edges, in_ready=0, 5th word dropped. Then out_ready=1 → the first 4 words emerge in order with addrs 0..3.
- Streaming: in_valid=out_ready=1 for 300 cycles with ADDR_W=8 → count ≤1 throughout, out_addr sequence ...0xFE, 0xFF, 0x00, 0x01, and each word is accepted exactly once.
- Clear: 3 words buffered, assert clear together with in_valid and out_ready → next cycle count=0, out_valid=0, out_addr=0, and no word is written.
- Async reset: assert reset_n=0 mid-cycle with 2 words buffered → outputs go to reset values without waiting for a clock edge. After release, the first push appears with out_addr=0.
